ddr_multiport_burst_arbiter: RTL

- Parametrised successor to the single-owner DDR cache interface.
- Arbitrates N_CH independent cache/DMA clients onto one DDR controller burst port (rd/wr_burst_* handshake), using round-robin fairness.
- Read bursts are streamed back to the owning channel; write data is pulled from the owning channel on each controller beat request.
- Sits between the instruction/data/interrupt caches and the DDR controller, replacing the fixed-command state machine.

---
 rtl/ddr_multiport_burst_arbiter_if.sv | 51 +++++
 rtl/ddr_multiport_burst_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ddr_multiport_burst_arbiter_if.sv
// Client-side and DDR-controller-side burst signals of the multiport arbiter.
// slave = arbiter view, master = clients plus controller view.
interface ddr_multiport_burst_arbiter_if #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned CLI_DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 10
) ();
  logic [N_CH-1:0]                cli_req;
  logic [N_CH-1:0]                cli_we;
  logic [N_CH*DDR_ADDR_WIDTH-1:0] cli_addr;
  logic [N_CH*LEN_WIDTH-1:0]      cli_len;
  logic [N_CH*CLI_DATA_WIDTH-1:0] cli_wr_data;
  logic [N_CH-1:0]                cli_gnt;
  logic [N_CH-1:0]                cli_wr_pull;
  logic [CLI_DATA_WIDTH-1:0]      cli_rd_data;
  logic [N_CH-1:0]                cli_rd_valid;
  logic [N_CH-1:0]                cli_done;
  logic [N_CH-1:0]                cli_err;
  logic                           rd_burst_req;
  logic                           wr_burst_req;
  logic [LEN_WIDTH-1:0]           rd_burst_len;
  logic [LEN_WIDTH-1:0]           wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0]      rd_burst_addr;
  logic [DDR_ADDR_WIDTH-1:0]      wr_burst_addr;
  logic                           rd_burst_data_valid;
  logic [DDR_DATA_WIDTH-1:0]      rd_burst_data;
  logic                           wr_burst_data_req;
  logic [DDR_DATA_WIDTH-1:0]      wr_burst_data;
  logic                           rd_burst_finish;
  logic                           wr_burst_finish;

  modport slave (
    input  cli_req, cli_we, cli_addr, cli_len, cli_wr_data,
           rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
           rd_burst_finish, wr_burst_finish,
    output cli_gnt, cli_wr_pull, cli_rd_data, cli_rd_valid, cli_done, cli_err,
           rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data
  );

  modport master (
    output cli_req, cli_we, cli_addr, cli_len, cli_wr_data,
           rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
           rd_burst_finish, wr_burst_finish,
    input  cli_gnt, cli_wr_pull, cli_rd_data, cli_rd_valid, cli_done, cli_err,
           rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data
  );
endinterface

// File: rtl/ddr_multiport_burst_arbiter.sv
// Round-robin arbiter multiplexing N_CH cache/DMA clients onto one DDR
// controller burst port; reads stream back to the owner, writes are pulled per beat.
module ddr_multiport_burst_arbiter #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned CLI_DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 10
) (
  input logic                          mem_clk,
  input logic                          rst,
  ddr_multiport_burst_arbiter_if.slave bus
);
  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, ISSUE_RD, ISSUE_WR, RUN_RD, RUN_WR, DONE} state_t;
  state_t r_state, w_next;

  logic [IW-1:0]             r_rr, r_owner, w_pick;
  logic                      w_any;
  logic                      r_we;
  logic [DDR_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [CW-1:0]             r_cnt, w_cnt_final;
  logic [N_CH-1:0]           w_owner_oh, w_pull;
  logic [N_CH-1:0]           r_gnt, r_rd_valid, r_done, r_err;
  logic [CLI_DATA_WIDTH-1:0] r_rd_data;
  logic                      r_rd_req, r_wr_req;
  logic [LEN_WIDTH-1:0]      r_rd_len, r_wr_len;
  logic [DDR_ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [DDR_DATA_WIDTH-1:0] r_wr_data;
  logic                      w_beat;

  // First requester at or after the round-robin pointer, wrapping modulo N_CH.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!w_any && bus.cli_req[(32'(r_rr) + i) % N_CH]) begin
        w_any  = 1'b1;
        w_pick = IW'((32'(r_rr) + i) % N_CH);
      end
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_pull      = (r_state == RUN_WR && bus.wr_burst_data_req) ? w_owner_oh : '0;
  assign w_beat      = (r_state == RUN_RD) ? bus.rd_burst_data_valid : bus.wr_burst_data_req;
  assign w_cnt_final = r_cnt + CW'(w_beat);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A zero-length request still passes through ISSUE so the grant and done
  // pulses keep their usual spacing, but no controller request is raised.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_any) w_next = bus.cli_we[w_pick] ? ISSUE_WR : ISSUE_RD;
      ISSUE_RD: w_next = (r_len == '0) ? DONE : RUN_RD;
      ISSUE_WR: w_next = (r_len == '0) ? DONE : RUN_WR;
      RUN_RD:   if (bus.rd_burst_finish) w_next = DONE;
      RUN_WR:   if (bus.wr_burst_finish) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_rr       <= '0;
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_rd_data  <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_len   <= '0;
      r_wr_len   <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_done     <= '0;
      if (r_state != RUN_WR) r_wr_data <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_owner       <= w_pick;
          r_we          <= bus.cli_we[w_pick];
          r_addr        <= bus.cli_addr[w_pick*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
          r_len         <= bus.cli_len[w_pick*LEN_WIDTH +: LEN_WIDTH];
          r_gnt[w_pick] <= 1'b1;
        end
        ISSUE_RD: begin
          r_cnt <= '0;
          if (r_len != '0) begin
            r_rd_req  <= 1'b1;
            r_rd_len  <= r_len;
            r_rd_addr <= r_addr;
          end
        end
        ISSUE_WR: begin
          r_cnt <= '0;
          if (r_len != '0) begin
            r_wr_req  <= 1'b1;
            r_wr_len  <= r_len;
            r_wr_addr <= r_addr;
          end
        end
        RUN_RD: begin
          if (bus.rd_burst_data_valid) begin
            r_rd_data  <= bus.rd_burst_data[CLI_DATA_WIDTH-1:0];
            r_rd_valid <= w_owner_oh;
            r_cnt      <= w_cnt_final;
          end
          if (bus.rd_burst_finish) begin
            r_rd_req  <= 1'b0;
            r_rd_len  <= '0;
            r_rd_addr <= '0;
            if (w_cnt_final != CW'(r_len)) r_err[r_owner] <= 1'b1;
          end
        end
        RUN_WR: begin
          if (bus.wr_burst_data_req) begin
            r_wr_data <= DDR_DATA_WIDTH'(bus.cli_wr_data[r_owner*CLI_DATA_WIDTH +: CLI_DATA_WIDTH]);
            r_cnt     <= w_cnt_final;
          end
          if (bus.wr_burst_finish) begin
            r_wr_req  <= 1'b0;
            r_wr_len  <= '0;
            r_wr_addr <= '0;
            if (w_cnt_final != CW'(r_len)) r_err[r_owner] <= 1'b1;
          end
        end
        DONE: begin
          r_done[r_owner] <= 1'b1;
          r_rr            <= (r_owner == IW'(N_CH - 1)) ? '0 : r_owner + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.cli_gnt       = r_gnt;
  assign bus.cli_wr_pull   = w_pull;
  assign bus.cli_rd_data   = r_rd_data;
  assign bus.cli_rd_valid  = r_rd_valid;
  assign bus.cli_done      = r_done;
  assign bus.cli_err       = r_err;
  assign bus.rd_burst_req  = r_rd_req;
  assign bus.wr_burst_req  = r_wr_req;
  assign bus.rd_burst_len  = r_rd_len;
  assign bus.wr_burst_len  = r_wr_len;
  assign bus.rd_burst_addr = r_rd_addr;
  assign bus.wr_burst_addr = r_wr_addr;
  assign bus.wr_burst_data = r_wr_data;
endmodule
